// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect sequencer: PC enable, slot-1/slot-2 redirect pulses, pending buffer and flush window.
// Optional performance counters are enabled by defining FC_PERF_CNT_EN.
module fetch_redirect_ctrl #(
    parameter int PC_WIDTH     = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                fc_i_clk,
    input  logic                fc_i_rst,
    input  logic                fc_i_en,
    input  logic                fc_i_stall,
    input  logic                fc_i_br_valid_1,
    input  logic [PC_WIDTH-1:0] fc_i_br_target_1,
    input  logic                fc_i_br_valid_2,
    input  logic [PC_WIDTH-1:0] fc_i_br_target_2,
    output logic                fc_o_pc_ce,
    output logic                fc_o_change_pc_1,
    output logic                fc_o_change_pc_2,
    output logic [PC_WIDTH-1:0] fc_o_pc_1,
    output logic [PC_WIDTH-1:0] fc_o_pc_2,
    output logic                fc_o_flush,
    output logic                fc_o_pending,
`ifdef FC_PERF_CNT_EN
    output logic [31:0]         fc_o_redirect_cnt,
    output logic [31:0]         fc_o_stall_cnt,
`endif
    output logic [1:0]          fc_o_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t              state;
    logic [3:0]          flush_cnt;
    logic                buf_valid;
    logic                buf_slot2;
    logic [PC_WIDTH-1:0] buf_target;

    logic                br_any;
    logic                br_slot2;
    logic [PC_WIDTH-1:0] br_target;
    logic                from_buf;
    logic                issue;
    logic                issue_slot2;
    logic [PC_WIDTH-1:0] issue_target;

    // Slot 1 is older, so when both request, slot 2 is on the wrong path.
    assign br_any    = fc_i_br_valid_1 | fc_i_br_valid_2;
    assign br_slot2  = ~fc_i_br_valid_1;
    assign br_target = fc_i_br_valid_1 ? fc_i_br_target_1 : fc_i_br_target_2;

    // A buffered redirect is older than anything arriving now and wins.
    assign from_buf     = (state == HOLD) && buf_valid;
    assign issue        = fc_i_en && !fc_i_stall &&
                          (((state == RUN) && br_any) || ((state == HOLD) && (buf_valid || br_any)));
    assign issue_slot2  = from_buf ? buf_slot2  : br_slot2;
    assign issue_target = from_buf ? buf_target : br_target;

    assign fc_o_state = state;

    always_ff @(posedge fc_i_clk or negedge fc_i_rst) begin
        if (!fc_i_rst) begin
            state            <= IDLE;
            flush_cnt        <= 4'd0;
            buf_valid        <= 1'b0;
            buf_slot2        <= 1'b0;
            buf_target       <= '0;
            fc_o_pc_ce       <= 1'b0;
            fc_o_change_pc_1 <= 1'b0;
            fc_o_change_pc_2 <= 1'b0;
            fc_o_pc_1        <= '0;
            fc_o_pc_2        <= '0;
            fc_o_flush       <= 1'b0;
            fc_o_pending     <= 1'b0;
        end else if (!fc_i_en) begin
            state            <= IDLE;
            flush_cnt        <= 4'd0;
            buf_valid        <= 1'b0;
            buf_slot2        <= 1'b0;
            buf_target       <= '0;
            fc_o_pc_ce       <= 1'b0;
            fc_o_change_pc_1 <= 1'b0;
            fc_o_change_pc_2 <= 1'b0;
            fc_o_flush       <= 1'b0;
            fc_o_pending     <= 1'b0;
        end else begin
            fc_o_change_pc_1 <= 1'b0;
            fc_o_change_pc_2 <= 1'b0;
            if (issue) begin
                fc_o_change_pc_1 <= ~issue_slot2;
                fc_o_change_pc_2 <= issue_slot2;
                if (issue_slot2) fc_o_pc_2 <= issue_target;
                else             fc_o_pc_1 <= issue_target;
                fc_o_pc_ce   <= 1'b1;
                fc_o_flush   <= 1'b1;
                flush_cnt    <= FLUSH_LOAD;
                buf_valid    <= 1'b0;
                fc_o_pending <= 1'b0;
                state        <= FLUSH;
            end else begin
                case (state)
                    IDLE: begin
                        fc_o_pc_ce <= 1'b1;
                        state      <= RUN;
                    end
                    RUN: begin
                        if (fc_i_stall) begin
                            fc_o_pc_ce <= 1'b0;
                            state      <= HOLD;
                            if (br_any) begin
                                buf_valid    <= 1'b1;
                                buf_slot2    <= br_slot2;
                                buf_target   <= br_target;
                                fc_o_pending <= 1'b1;
                            end
                        end else begin
                            fc_o_pc_ce <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (!fc_i_stall) begin
                            fc_o_pc_ce <= 1'b1;
                            state      <= RUN;
                        end else begin
                            fc_o_pc_ce <= 1'b0;
                            if (br_any && !buf_valid) begin
                                buf_valid    <= 1'b1;
                                buf_slot2    <= br_slot2;
                                buf_target   <= br_target;
                                fc_o_pending <= 1'b1;
                            end
                        end
                    end
                    FLUSH: begin
                        fc_o_pc_ce <= ~fc_i_stall;
                        if (flush_cnt <= 4'd1) begin
                            flush_cnt  <= 4'd0;
                            fc_o_flush <= 1'b0;
                            state      <= fc_i_stall ? HOLD : RUN;
                        end else begin
                            flush_cnt <= flush_cnt - 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef FC_PERF_CNT_EN
    always_ff @(posedge fc_i_clk or negedge fc_i_rst) begin
        if (!fc_i_rst) begin
            fc_o_redirect_cnt <= 32'd0;
            fc_o_stall_cnt    <= 32'd0;
        end else begin
            if (issue) fc_o_redirect_cnt <= fc_o_redirect_cnt + 32'd1;
            if ((state != IDLE) && fc_i_stall) fc_o_stall_cnt <= fc_o_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Sequencer for the dual-issue program counter.
- Generates the PC clock-enable and the slot-1/slot-2 redirect pulses and targets.
- Arbitrates branch redirects from the two execute slots, honours downstream stall, and buffers a redirect that arrives while fetch is held.
- Drives a flush window to the fetch/decode pipeline after every redirect.

Parameters:
- PC_WIDTH, 32, width of all PC/target values.
- FLUSH_CYCLES, 2, cycles fc_o_flush stays high after a redirect; legal range 1..15, 4-bit counter.

Ports:
- fc_i_clk  in  1  clock, rising edge.
- fc_i_rst  in  1  asynchronous, active-low reset.
- fc_i_en  in  1  global fetch enable.
- fc_i_stall  in  1  downstream backpressure (decode queue full).
- fc_i_br_valid_1  in  1  redirect request, slot 1 (older instruction).
- fc_i_br_target_1  in  PC_WIDTH  slot-1 target.
- fc_i_br_valid_2  in  1  redirect request, slot 2 (younger instruction).
- fc_i_br_target_2  in  PC_WIDTH  slot-2 target.
- fc_o_pc_ce  out  1  PC enable.
- fc_o_change_pc_1  out  1  one-cycle redirect pulse, target on fc_o_pc_1.
- fc_o_change_pc_2  out  1  one-cycle redirect pulse, target on fc_o_pc_2.
- fc_o_pc_1  out  PC_WIDTH  slot-1 redirect target.
- fc_o_pc_2  out  PC_WIDTH  slot-2 redirect target.
- fc_o_flush  out  1  squash in-flight fetch pairs.
- fc_o_pending  out  1  a buffered redirect is waiting.

Behaviour:
- Timing:
  - All outputs are registered.
  - Every response appears on the edge after the input is sampled.
- Reset (fc_i_rst=0, asynchronous):
  - state=IDLE.
  - All outputs 0, pending buffer cleared, flush counter 0.
- States: IDLE, RUN, HOLD, FLUSH.
- IDLE:
  - pc_ce=0.
  - fc_i_en=1 -> RUN with pc_ce=1 next cycle.
  - Redirect inputs are ignored.
- RUN:
  - pc_ce=1.
  - Slot 1 has priority. If both valids are high, slot 2 is discarded as wrong-path.
  - Accepted redirect with stall=0: next cycle assert change_pc_1 (or change_pc_2) for exactly 1 cycle, load the target into fc_o_pc_1 (or fc_o_pc_2), keep pc_ce=1, set flush=1, load counter=FLUSH_CYCLES, go to FLUSH.
  - stall=1 with no redirect: pc_ce=0, go to HOLD.
  - stall=1 and redirect in the same cycle: capture the redirect into the pending buffer (valid, slot select, target), pc_ce=0, go to HOLD.
- HOLD:
  - pc_ce=0, no change pulses.
  - Redirect arriving with buffer empty: captured, fc_o_pending=1.
  - Redirect arriving with buffer full: dropped. The buffered one is older and its redirect squashes the newer.
  - stall falls with buffer full: issue the buffered redirect exactly as in RUN, clear the buffer, go to FLUSH.
  - stall falls with buffer empty: go to RUN, pc_ce=1.
- FLUSH:
  - flush=1 while counter>0; counter decrements each cycle, including while stalled.
  - Redirect inputs are ignored (wrong-path).
  - pc_ce = not stall.
  - Counter reaches 0: flush=0, then go to HOLD if stall=1, else RUN.
- Change pulses: never both high in one cycle.
- Target hold: fc_o_pc_1/2 keep their last target between redirects.
- fc_i_en=0 in any state: next cycle go to IDLE. Outputs pc_ce, change pulses, flush and pending go to 0; buffer and counter are cleared; targets are held.
- Reset mid-FLUSH or mid-HOLD: the pending redirect is lost and no pulse is issued.

Optional Feature:
- Macro: FC_PERF_CNT_EN.
- Defined:
  - Adds output fc_o_redirect_cnt (32 bit), incremented once per issued change pulse.
  - Adds output fc_o_stall_cnt (32 bit), incremented each cycle with state in {RUN, HOLD, FLUSH} and stall=1.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: the counters and their ports are absent; all other behaviour is identical.

Test Plan:
- Reset release, en=1 at cycle 0, no stall -> pc_ce=1 from cycle 1; change pulses and flush stay 0 for 20 cycles.
- RUN, br_valid_1=1 target=0x40 and br_valid_2=1 target=0x80 in the same cycle -> next cycle change_pc_1=1 for 1 cycle, fc_o_pc_1=0x40, change_pc_2=0; flush high 2 cycles; a br_valid_2 during flush produces no pulse.
- RUN, stall=1 with br_valid_2=1 target=0x100, then br_valid_1=1 target=0x200 while still stalled, stall falls 3 cycles later -> pending=1 during hold; exactly one change_pc_2 pulse with fc_o_pc_2=0x100 the cycle after stall falls; 0x200 never issued.
- FLUSH_CYCLES=3, redirect followed by stall=1 during the second flush cycle -> flush still ends after 3 cycles; pc_ce=0 while stalled; state HOLD, then RUN after stall falls.
- en=0 during HOLD with a pending redirect, then en=1 -> IDLE, pending cleared, no change pulse ever issued, pc_ce=1 one cycle after en rises.
- FC_PERF_CNT_EN defined, 5 redirects and 7 stall cycles -> redirect_cnt=5, stall_cnt=7; async reset mid-run -> both counters 0 immediately.
